// File: rtl/custom_pkg.sv
// Shared decode/issue definitions: operand-select encodings, issue-buffer
// occupancy states and the canonical ID->EX payload layout.
package custom_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 64;

    // First ALU operand source; encoding 3 is unused and behaves as OP1_RS1
    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_e;

    // Second ALU operand source
    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_e;

    // Issue buffer occupancy: main entry only, or main plus skid entry
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // Everything the execute stage receives for one instruction
    typedef struct packed {
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   store_data;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } issue_payload_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: index 0 picks register-file data, index k in
// 1..NUM_FWD picks forwarding source k-1, anything larger falls back to the
// register file.
module fwd_mux #(
    parameter int unsigned NUM_FWD = 4,
    parameter int unsigned XLEN    = 32,
    localparam int unsigned SEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [XLEN-1:0]         rf_data_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    output logic [XLEN-1:0]         data_o
);

    // Default to regfile data so out-of-range selects need no special case
    always_comb begin
        data_o = rf_data_i;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (sel_i == SEL_W'(k + 1)) begin
                data_o = fwd_data_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/decode_issue_buf.sv
// ID->EX issue stage: resolves forwarded operands, applies the load-use
// interlock and holds results in a two-entry skid buffer with valid/ready
// handshakes on both sides and a flush that kills buffered and incoming work.
module decode_issue_buf #(
    parameter int unsigned XLEN    = custom_pkg::XLEN,
    parameter int unsigned NUM_FWD = 4,
    parameter int unsigned CTRL_W  = custom_pkg::CTRL_W,
    localparam int unsigned SEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [XLEN-1:0]         pc_plus4_i,
    input  logic [4:0]              rs1_addr_i,
    input  logic [4:0]              rs2_addr_i,
    input  logic [4:0]              rd_addr_i,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         rs2_data_i,
    input  logic [XLEN-1:0]         imm_i,
    input  logic [CTRL_W-1:0]       ctrl_i,
    input  logic [1:0]              op1_sel_i,
    input  logic                    op2_sel_i,
    input  logic                    uses_rs1_i,
    input  logic                    uses_rs2_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    input  logic [SEL_W-1:0]        fwd_sel_a_i,
    input  logic [SEL_W-1:0]        fwd_sel_b_i,
    input  logic                    ex_is_load_i,
    input  logic [4:0]              ex_rd_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         out_pc_plus4_o,
    output logic [XLEN-1:0]         out_op1_o,
    output logic [XLEN-1:0]         out_op2_o,
    output logic [XLEN-1:0]         out_store_data_o,
    output logic [4:0]              out_rd_o,
    output logic [CTRL_W-1:0]       out_ctrl_o
);

    import custom_pkg::*;

    // Same field order as issue_payload_t, but sized from this instance's
    // parameters so XLEN/CTRL_W overrides stay consistent.
    typedef struct packed {
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   store_data;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    buf_state_e      state;
    payload_t        main_q;
    payload_t        skid_q;
    payload_t        in_payload;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic            hazard;
    logic            skid_valid;
    logic            in_fire;
    logic            out_fire;

    fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .XLEN    (XLEN)
    ) u_fwd_a (
        .sel_i      (fwd_sel_a_i),
        .rf_data_i  (rs1_data_i),
        .fwd_data_i (fwd_data_i),
        .data_o     (fwd_a)
    );

    fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .XLEN    (XLEN)
    ) u_fwd_b (
        .sel_i      (fwd_sel_b_i),
        .rf_data_i  (rs2_data_i),
        .fwd_data_i (fwd_data_i),
        .data_o     (fwd_b)
    );

    // Assemble the resolved payload for the instruction on the input side
    always_comb begin
        in_payload            = '0;
        in_payload.pc_plus4   = pc_plus4_i;
        in_payload.store_data = fwd_b;
        in_payload.rd         = rd_addr_i;
        in_payload.ctrl       = ctrl_i;
        in_payload.op2        = (op2_sel_i == OP2_IMM) ? imm_i : fwd_b;
        case (op1_sel_i)
            OP1_PC:   in_payload.op1 = pc_i;
            OP1_ZERO: in_payload.op1 = '0;
            default:  in_payload.op1 = fwd_a;
        endcase
    end

    // A consumer of the load in EX cannot issue until the load data is forwardable
    assign hazard = in_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                    ((uses_rs1_i & (rs1_addr_i == ex_rd_i)) |
                     (uses_rs2_i & (rs2_addr_i == ex_rd_i)));

    assign skid_valid = (state == BUF_TWO);
    assign in_ready_o = ~skid_valid & ~hazard;
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_valid_o = (state != BUF_EMPTY);
    assign out_fire   = out_valid_o & out_ready_i;

    assign out_pc_plus4_o   = main_q.pc_plus4;
    assign out_op1_o        = main_q.op1;
    assign out_op2_o        = main_q.op2;
    assign out_store_data_o = main_q.store_data;
    assign out_rd_o         = main_q.rd;
    assign out_ctrl_o       = main_q.ctrl;

    // Skid buffer occupancy and payload movement; reset beats flush beats handshakes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= BUF_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            state  <= BUF_EMPTY;
            skid_q <= '0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_payload;
                        state  <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_payload;
                    end else if (in_fire) begin
                        skid_q <= in_payload;
                        state  <= BUF_TWO;
                    end else if (out_fire) begin
                        state  <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= BUF_ONE;
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_issue_buf.sv
// Scoreboard bench for decode_issue_buf: the driver computes each accepted
// instruction's expected EX payload from the operand rules and queues it;
// the monitor pops and compares whenever EX takes an output.
module tb_decode_issue_buf;

    localparam int XLEN = 32;
    localparam int NF   = 4;
    localparam int CW   = 64;
    localparam int SW   = 3;

    logic            clk = 1'b0;
    logic            rst_i, in_valid_i, in_ready_o;
    logic [XLEN-1:0] pc_i, pc_plus4_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]      rs1_addr_i, rs2_addr_i, rd_addr_i, ex_rd_i;
    logic [CW-1:0]   ctrl_i;
    logic [1:0]      op1_sel_i;
    logic            op2_sel_i, uses_rs1_i, uses_rs2_i, ex_is_load_i, flush_i;
    logic [NF*XLEN-1:0] fwd_data_i;
    logic [SW-1:0]   fwd_sel_a_i, fwd_sel_b_i;
    logic            out_valid_o, out_ready_i;
    logic [XLEN-1:0] out_pc_plus4_o, out_op1_o, out_op2_o, out_store_data_o;
    logic [4:0]      out_rd_o;
    logic [CW-1:0]   out_ctrl_o;

    logic [XLEN-1:0] fwd_arr [NF];

    always #5 clk = ~clk;

    always_comb begin
        fwd_data_i = '0;
        for (int k = 0; k < NF; k++) fwd_data_i[k*XLEN +: XLEN] = fwd_arr[k];
    end

    decode_issue_buf #(.XLEN(XLEN), .NUM_FWD(NF), .CTRL_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .pc_plus4_i(pc_plus4_i), .rs1_addr_i(rs1_addr_i),
        .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i), .imm_i(imm_i), .ctrl_i(ctrl_i),
        .op1_sel_i(op1_sel_i), .op2_sel_i(op2_sel_i), .uses_rs1_i(uses_rs1_i),
        .uses_rs2_i(uses_rs2_i), .fwd_data_i(fwd_data_i), .fwd_sel_a_i(fwd_sel_a_i),
        .fwd_sel_b_i(fwd_sel_b_i), .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_plus4_o(out_pc_plus4_o), .out_op1_o(out_op1_o), .out_op2_o(out_op2_o),
        .out_store_data_o(out_store_data_o), .out_rd_o(out_rd_o), .out_ctrl_o(out_ctrl_o)
    );

    typedef struct {
        logic [XLEN-1:0] pp4, op1, op2, sd;
        logic [4:0]      rd;
        logic [CW-1:0]   ctrl;
    } exp_t;

    exp_t q[$];
    int   occ_start = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] pick(input int sel, input logic [XLEN-1:0] rf);
        if (sel >= 1 && sel <= NF) return fwd_arr[sel-1];
        return rf;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [XLEN-1:0] a, b;
        a = pick(int'(fwd_sel_a_i), rs1_data_i);
        b = pick(int'(fwd_sel_b_i), rs2_data_i);
        e.pp4 = pc_plus4_i;
        if (op1_sel_i == 2'd1)      e.op1 = pc_i;
        else if (op1_sel_i == 2'd2) e.op1 = '0;
        else                        e.op1 = a;
        e.op2  = op2_sel_i ? imm_i : b;
        e.sd   = b;
        e.rd   = rd_addr_i;
        e.ctrl = ctrl_i;
        return e;
    endfunction

    function automatic bit model_hazard();
        bit r1, r2;
        r1 = uses_rs1_i && (rs1_addr_i == ex_rd_i);
        r2 = uses_rs2_i && (rs2_addr_i == ex_rd_i);
        return in_valid_i && ex_is_load_i && (ex_rd_i != 0) && (r1 || r2);
    endfunction

    // Monitor: expected occupancy drives out_valid; each EX handshake pops one entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            q.delete();
        end else begin
            check("out_valid", {63'd0, out_valid_o}, {63'd0, occ_start > 0});
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got pc_plus4 %h expected no output", out_pc_plus4_o);
                end else begin
                    e = q.pop_front();
                    check("pc_plus4", {32'd0, out_pc_plus4_o}, {32'd0, e.pp4});
                    check("op1", {32'd0, out_op1_o}, {32'd0, e.op1});
                    check("op2", {32'd0, out_op2_o}, {32'd0, e.op2});
                    check("store_data", {32'd0, out_store_data_o}, {32'd0, e.sd});
                    check("rd", {59'd0, out_rd_o}, {59'd0, e.rd});
                    check("ctrl", out_ctrl_o, e.ctrl);
                end
            end
            if (flush_i) q.delete();
        end
    end

    // One cycle: inputs already driven at posedge+1; check ready, queue accepted work
    task automatic tick();
        bit exp_ready;
        #1;
        occ_start = rst_i ? 0 : q.size();
        if (!rst_i) begin
            exp_ready = (occ_start < 2) && !model_hazard();
            check("in_ready", {63'd0, in_ready_o}, {63'd0, exp_ready});
            if (in_valid_i && exp_ready && !flush_i) q.push_back(model());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid_i = 0; pc_i = '0; pc_plus4_i = '0; rs1_addr_i = 5'd1; rs2_addr_i = 5'd2;
        rd_addr_i = 5'd3; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; ctrl_i = '0;
        op1_sel_i = 2'd0; op2_sel_i = 0; uses_rs1_i = 0; uses_rs2_i = 0;
        fwd_sel_a_i = '0; fwd_sel_b_i = '0; ex_is_load_i = 0; ex_rd_i = '0; flush_i = 0;
    endtask

    task automatic instr(input logic [31:0] pp4, input logic [31:0] pc, input logic [31:0] rs1d,
                         input logic [31:0] rs2d, input logic [31:0] imm, input logic [1:0] o1,
                         input logic o2, input int sa, input int sb);
        idle();
        in_valid_i = 1; pc_plus4_i = pp4; pc_i = pc; rs1_data_i = rs1d; rs2_data_i = rs2d;
        imm_i = imm; op1_sel_i = o1; op2_sel_i = o2;
        fwd_sel_a_i = SW'(sa); fwd_sel_b_i = SW'(sb);
        rd_addr_i = 5'($urandom_range(0, 31));
        ctrl_i = {$urandom, $urandom};
    endtask

    initial begin
        idle();
        out_ready_i = 1;
        for (int k = 0; k < NF; k++) fwd_arr[k] = 32'h11 * (k + 1);
        rst_i = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 0;
        check("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
        check("reset_pc_plus4", {32'd0, out_pc_plus4_o}, 64'd0);
        check("reset_ctrl", out_ctrl_o, 64'd0);

        // Back-to-back stream, one per cycle
        for (int i = 1; i <= 3; i++) begin
            instr(32'(4 * i), 32'(4 * i - 4), 32'h1, 32'h2, 32'(i), 2'd0, 1, 0, 0);
            tick();
            check("stream_out", {32'd0, out_pc_plus4_o}, 64'(4 * i));
        end
        idle(); tick();

        // Backpressure fills both entries and holds the head
        out_ready_i = 0;
        instr(32'h4, 0, 1, 2, 3, 2'd0, 1, 0, 0); tick();
        instr(32'h8, 4, 1, 2, 3, 2'd0, 1, 0, 0); tick();
        instr(32'hC, 8, 1, 2, 3, 2'd0, 1, 0, 0);
        #1 check("bp_in_ready", {63'd0, in_ready_o}, 64'd0);
        tick();
        check("bp_frozen", {32'd0, out_pc_plus4_o}, 64'h4);
        tick();
        out_ready_i = 1;
        tick();                       // head drains, C still blocked
        check("bp_second", {32'd0, out_pc_plus4_o}, 64'h8);
        tick();                       // C accepted behind 8
        idle(); tick(); tick();

        // Forwarding selects, including out-of-range fallback
        instr(32'h40, 0, 32'hAA, 32'hBB, 0, 2'd0, 0, 3, 0); tick();
        check("fwd_op1", {32'd0, out_op1_o}, 64'h33);
        check("fwd_op2", {32'd0, out_op2_o}, 64'hBB);
        check("fwd_store", {32'd0, out_store_data_o}, 64'hBB);
        instr(32'h44, 0, 32'hAA, 32'hBB, 0, 2'd0, 0, 7, 0); tick();
        check("fwd_oob", {32'd0, out_op1_o}, 64'hAA);
        idle(); tick();

        // Load-use interlock inserts one bubble
        instr(32'h50, 0, 1, 2, 3, 2'd0, 0, 0, 0);
        rs1_addr_i = 5; uses_rs1_i = 1; ex_is_load_i = 1; ex_rd_i = 5;
        #1 check("lu_stall", {63'd0, in_ready_o}, 64'd0);
        tick();
        check("lu_bubble", {63'd0, out_valid_o}, 64'd0);
        ex_is_load_i = 0;
        tick();
        check("lu_accept", {32'd0, out_pc_plus4_o}, 64'h50);
        instr(32'h54, 0, 1, 2, 3, 2'd0, 0, 0, 0);
        rs1_addr_i = 0; uses_rs1_i = 1; ex_is_load_i = 1; ex_rd_i = 0;
        #1 check("lu_x0", {63'd0, in_ready_o}, 64'd1);
        tick();
        idle(); tick();

        // Flush with both entries full kills everything, including the incoming one
        out_ready_i = 0;
        instr(32'h60, 0, 1, 2, 3, 2'd0, 0, 0, 0); tick();
        instr(32'h64, 0, 1, 2, 3, 2'd0, 0, 0, 0); tick();
        instr(32'h68, 0, 1, 2, 3, 2'd0, 0, 0, 0); flush_i = 1; tick();
        idle();
        check("flush_empty", {63'd0, out_valid_o}, 64'd0);
        out_ready_i = 1;
        tick(); tick();

        // Operand source modes
        instr(32'h70, 32'h0, 32'hAA, 32'hBB, 32'h12345000, 2'd2, 1, 0, 0); tick();
        check("lui_op1", {32'd0, out_op1_o}, 64'd0);
        check("lui_op2", {32'd0, out_op2_o}, 64'h12345000);
        instr(32'h104, 32'h100, 32'hAA, 32'hBB, 32'h8, 2'd1, 1, 0, 0); tick();
        check("auipc_op1", {32'd0, out_op1_o}, 64'h100);
        idle(); tick();

        // Randomised traffic with hazards, flushes, stalls and occasional reset
        for (int n = 0; n < 3000; n++) begin
            in_valid_i   = ($urandom_range(0, 9) < 7);
            pc_i         = $urandom;
            pc_plus4_i   = $urandom;
            rs1_addr_i   = 5'($urandom_range(0, 3));
            rs2_addr_i   = 5'($urandom_range(0, 3));
            rd_addr_i    = 5'($urandom_range(0, 31));
            rs1_data_i   = $urandom;
            rs2_data_i   = $urandom;
            imm_i        = $urandom;
            ctrl_i       = {$urandom, $urandom};
            op1_sel_i    = 2'($urandom_range(0, 3));
            op2_sel_i    = 1'($urandom_range(0, 1));
            uses_rs1_i   = 1'($urandom_range(0, 1));
            uses_rs2_i   = 1'($urandom_range(0, 1));
            fwd_sel_a_i  = SW'($urandom_range(0, 7));
            fwd_sel_b_i  = SW'($urandom_range(0, 7));
            ex_is_load_i = ($urandom_range(0, 9) < 3);
            ex_rd_i      = 5'($urandom_range(0, 3));
            flush_i      = ($urandom_range(0, 99) < 5);
            out_ready_i  = ($urandom_range(0, 9) < 7);
            rst_i        = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < NF; k++) fwd_arr[k] = $urandom;
            tick();
        end
        rst_i = 0;
        idle();
        out_ready_i = 1;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
